mouse_report_tx: RTL and testbench

//  Consumer end of the cursor path: accumulates per-cycle dx/dy motion and the
//  one-cycle left/right click pulses, and emits 3-byte PS/2-style mouse packets
//  {status, X, Y} over a valid/ready byte stream at a fixed report rate.

---
 rtl/mouse_report_tx.sv | 166 ++++++++++++++++
 tb/tb_mouse_report_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mouse_report_tx.sv
// rtl/mouse_report_tx.sv - Motion/click accumulator emitting 3-byte PS/2-style mouse packets at a fixed rate.
module mouse_report_tx #(
    parameter int REPORT_DIV = 1000,
    parameter int ACC_W      = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_en,
    input  logic [7:0] dx,
    input  logic [7:0] dy,
    input  logic       left_click,
    input  logic       right_click,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       pkt_done
);

    localparam int CNT_W = (REPORT_DIV > 1) ? $clog2(REPORT_DIV) : 1;
    localparam int EXT_W = ACC_W + 2;
    localparam logic signed [EXT_W-1:0] ACC_MAX = EXT_W'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] ACC_MIN = -ACC_MAX;
    localparam logic signed [ACC_W-1:0] POS_127 = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] NEG_127 = -POS_127;

    typedef enum logic [1:0] {IDLE, S0, S1, S2} state_t;

    state_t                   state, state_next;
    logic [CNT_W-1:0]         tick_cnt;
    logic                     tick;
    logic                     tick_pend;
    logic signed [ACC_W-1:0]  acc_x, acc_y;
    logic                     lp, rp, rel;
    logic [7:0]               b0, b1, b2;
    logic                     launch;
    logic                     has_content;
    logic [7:0]               ex, ey;
    logic                     ox, oy;
    logic signed [ACC_W-1:0]  sub_x, sub_y;
    logic signed [ACC_W-1:0]  acc_x_next, acc_y_next;

    // Saturating a - s + d, evaluated two bits wider so no intermediate overflow.
    function automatic logic signed [ACC_W-1:0] sat_update(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] s,
        input logic                    en,
        input logic [7:0]              d
    );
        logic signed [EXT_W-1:0] sum;
        logic signed [EXT_W-1:0] dext;
        dext = en ? {{(EXT_W-8){d[7]}}, d} : '0;
        sum  = {{2{a[ACC_W-1]}}, a} - {{2{s[ACC_W-1]}}, s} + dext;
        if (sum > ACC_MAX)
            return ACC_MAX[ACC_W-1:0];
        else if (sum < ACC_MIN)
            return ACC_MIN[ACC_W-1:0];
        else
            return sum[ACC_W-1:0];
    endfunction

    function automatic logic [8:0] clamp127(input logic signed [ACC_W-1:0] a);
        if (a > POS_127)
            return {1'b1, 8'sd127};
        else if (a < NEG_127)
            return {1'b1, -8'sd127};
        else
            return {1'b0, a[7:0]};
    endfunction

    assign tick = (tick_cnt == CNT_W'(REPORT_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign {ox, ex} = clamp127(acc_x);
    assign {oy, ey} = clamp127(acc_y);
    assign has_content = (acc_x != '0) || (acc_y != '0) || lp || rp || rel;

    assign sub_x = launch ? {{(ACC_W-8){ex[7]}}, ex} : '0;
    assign sub_y = launch ? {{(ACC_W-8){ey[7]}}, ey} : '0;
    assign acc_x_next = sat_update(acc_x, sub_x, move_en, dx);
    assign acc_y_next = sat_update(acc_y, sub_y, move_en, dy);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        tx_data    = 8'h00;
        case (state)
            IDLE: begin
                if ((tick || tick_pend) && has_content) begin
                    launch     = 1'b1;
                    state_next = S0;
                end
            end
            S0: begin
                tx_data = b0;
                if (tx_ready) state_next = S1;
            end
            S1: begin
                tx_data = b1;
                if (tx_ready) state_next = S2;
            end
            S2: begin
                tx_data = b2;
                if (tx_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx_valid = (state != IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_x     <= '0;
            acc_y     <= '0;
            lp        <= 1'b0;
            rp        <= 1'b0;
            rel       <= 1'b0;
            tick_pend <= 1'b0;
            b0        <= 8'h00;
            b1        <= 8'h00;
            b2        <= 8'h00;
            pkt_done  <= 1'b0;
        end else begin
            acc_x    <= acc_x_next;
            acc_y    <= acc_y_next;
            pkt_done <= (state == S2) && tx_ready;
            // Any tick seen in IDLE is consumed, whether or not it launched.
            if (state == IDLE)
                tick_pend <= 1'b0;
            else if (tick)
                tick_pend <= 1'b1;
            if (launch) begin
                b0  <= {oy, ox, ey[7], ex[7], 1'b1, 1'b0, rp, lp};
                b1  <= ex;
                b2  <= ey;
                rel <= lp | rp;
                // A click landing on the launch cycle belongs to the next packet.
                lp  <= left_click;
                rp  <= right_click;
            end else begin
                lp  <= lp | left_click;
                rp  <= rp | right_click;
            end
        end
    end

endmodule

// File: tb/tb_mouse_report_tx.sv
// tb/tb_mouse_report_tx.sv - Directed self-checking bench for mouse_report_tx.
module tb_mouse_report_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       move_en = 1'b0;
    logic [7:0] dx = 8'h00;
    logic [7:0] dy = 8'h00;
    logic       left_click = 1'b0;
    logic       right_click = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       pkt_done;

    int checks = 0;
    int errors = 0;

    mouse_report_tx #(.REPORT_DIV(16), .ACC_W(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .move_en    (move_en),
        .dx         (dx),
        .dy         (dy),
        .left_click (left_click),
        .right_click(right_click),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .pkt_done   (pkt_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic move(input logic [7:0] mx, input logic [7:0] my);
        move_en = 1'b1;
        dx = mx;
        dy = my;
        @(negedge clk);
        move_en = 1'b0;
        dx = 8'h00;
        dy = 8'h00;
    endtask

    task automatic wait_valid(input string tag);
        for (int w = 0; w < 60 && !tx_valid; w++) @(negedge clk);
        chk({tag, "_valid"}, tx_valid, 1);
    endtask

    task automatic get_pkt(input string tag, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] got [3];
        int n;
        n = 0;
        got[0] = 8'h00; got[1] = 8'h00; got[2] = 8'h00;
        wait_valid(tag);
        for (int c = 0; c < 10 && n < 3; c++) begin
            if (tx_valid && tx_ready) begin
                got[n] = tx_data;
                n++;
            end
            @(negedge clk);
        end
        chk({tag, "_b0"}, got[0], e0);
        chk({tag, "_b1"}, got[1], e1);
        chk({tag, "_b2"}, got[2], e2);
        chk({tag, "_done"}, {pkt_done, busy}, 2'b10);
    endtask

    task automatic silence(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (tx_valid) seen = 1'b1;
        end
        chk({tag, "_silence"}, seen, 0);
    endtask

    initial begin
        logic stable;
        @(negedge clk);
        do_reset();
        chk("rst_out", {tx_data, tx_valid, busy, pkt_done}, 11'h000);

        // Single small move, negative Y
        move(8'd5, 8'hFD);
        get_pkt("t1", 8'h28, 8'h05, 8'hFD);
        silence("t1", 40);

        // Click then automatic release report
        do_reset();
        left_click = 1'b1;
        @(negedge clk);
        left_click = 1'b0;
        get_pkt("t2a", 8'h09, 8'h00, 8'h00);
        get_pkt("t2b", 8'h08, 8'h00, 8'h00);
        silence("t2", 40);

        // Large motion drained over several packets with overflow flag
        do_reset();
        move(8'd100, 8'd0);
        move(8'd100, 8'd0);
        move(8'd100, 8'd0);
        get_pkt("t3a", 8'h48, 8'h7F, 8'h00);
        get_pkt("t3b", 8'h48, 8'h7F, 8'h00);
        get_pkt("t3c", 8'h08, 8'h2E, 8'h00);

        // Backpressure during byte 1, tick while busy queues the next packet
        do_reset();
        tx_ready = 1'b0;
        move(8'd1, 8'd0);
        wait_valid("t4");
        chk("t4_b0", tx_data, 8'h08);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk("t4_b1", tx_data, 8'h01);
        move(8'd2, 8'd0);
        stable = 1'b1;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (!(tx_valid && tx_data == 8'h01)) stable = 1'b0;
        end
        chk("t4_hold", stable, 1);
        tx_ready = 1'b1;
        @(negedge clk);
        chk("t4_b2", tx_data, 8'h00);
        @(negedge clk);
        chk("t4_done", {pkt_done, busy}, 2'b10);
        @(negedge clk);
        chk("t4_relaunch", {tx_valid, tx_data}, 9'h108);
        get_pkt("t4b", 8'h08, 8'h02, 8'h00);

        // Right click coinciding with launch cycle
        do_reset();
        move(8'd3, 8'd0);
        for (int c = 0; c < 14; c++) @(negedge clk);
        right_click = 1'b1;
        @(negedge clk);
        right_click = 1'b0;
        get_pkt("t5a", 8'h08, 8'h03, 8'h00);
        get_pkt("t5b", 8'h0A, 8'h00, 8'h00);
        get_pkt("t5c", 8'h08, 8'h00, 8'h00);
        silence("t5", 40);

        // Reset mid-packet aborts without resume
        do_reset();
        move(8'd4, 8'd0);
        wait_valid("t6");
        @(negedge clk);
        chk("t6_b1", tx_data, 8'h04);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_abort", {tx_valid, busy}, 2'b00);
        rst = 1'b0;
        silence("t6", 40);
        move(8'd0, 8'd1);
        get_pkt("t6b", 8'h08, 8'h00, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
